// File: rtl/control_sequencer.sv
// control_sequencer: microcoded T-state sequencer and CF/ZF flags for the 8-bit breadboard computer
module control_sequencer #(
  parameter int NUM_STEPS = 5,
  parameter int STEP_W    = 3,
  parameter bit EARLY_END = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ena,
  input  logic [3:0]        opcode,
  input  logic              carry_in,
  input  logic              zero_in,
  output logic [15:0]       control_word,
  output logic [STEP_W-1:0] step,
  output logic              CF,
  output logic              ZF,
  output logic              halted
);
  localparam logic [STEP_W-1:0] T0   = STEP_W'(0);
  localparam logic [STEP_W-1:0] T1   = STEP_W'(1);
  localparam logic [STEP_W-1:0] T2   = STEP_W'(2);
  localparam logic [STEP_W-1:0] T3   = STEP_W'(3);
  localparam logic [STEP_W-1:0] T4   = STEP_W'(4);
  localparam logic [STEP_W-1:0] LAST = STEP_W'(NUM_STEPS - 1);
  logic [15:0] exec_word;
  always_comb begin
    exec_word = 16'h0000;
    case (opcode)
      4'h1: exec_word = step == T2 ? 16'h0012 : step == T3 ? 16'h0048 : 16'h0000;
      4'h2: exec_word = step == T2 ? 16'h0012 : step == T3 ? 16'h0408 : step == T4 ? 16'h8140 : 16'h0000;
      4'h3: exec_word = step == T2 ? 16'h0012 : step == T3 ? 16'h0408 : step == T4 ? 16'h8340 : 16'h0000;
      4'h4: exec_word = step == T2 ? 16'h0012 : step == T3 ? 16'h0084 : 16'h0000;
      4'h5: exec_word = step == T2 ? 16'h0050 : 16'h0000;
      4'h6: exec_word = step == T2 ? 16'h4010 : 16'h0000;
      4'h7: exec_word = step == T2 && CF ? 16'h4010 : 16'h0000;
      4'h8: exec_word = step == T2 && ZF ? 16'h4010 : 16'h0000;
      4'hE: exec_word = step == T2 ? 16'h0880 : 16'h0000;
      4'hF: exec_word = step == T2 ? 16'h0001 : 16'h0000;
      default: exec_word = 16'h0000;
    endcase
  end
  assign control_word = step == T0 ? 16'h2002 : step == T1 ? 16'h1028 : exec_word;
  assign halted = control_word[0];
  // jumps decode from the pre-edge flags, so the FI update below never affects this cycle's word
  always_ff @(posedge clk) begin
    if (!clr) begin
      step <= T0;
      CF   <= 1'b0;
      ZF   <= 1'b0;
    end else if (ena) begin
      step <= halted ? step
            : (EARLY_END && step >= T2 && control_word == 16'h0000) || step == LAST ? T0
            : step + STEP_W'(1);
      if (control_word[15]) begin
        CF <= carry_in;
        ZF <= zero_in;
      end
    end
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench comparing two sequencer builds (EARLY_END 1 and 0) with a table model
module tb_control_sequencer;
  logic clk = 1'b0;
  logic clr = 1'b0;
  logic ena = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic carry_in = 1'b0;
  logic zero_in = 1'b0;
  logic [15:0] cw_e, cw_n;
  logic [2:0] st_e, st_n;
  logic cf_e, cf_n, zf_e, zf_n, h_e, h_n;
  int total = 0;
  int bad = 0;
  int cycle = 0;
  logic [21:0] q_e[$];
  logic [21:0] q_n[$];
  logic [15:0] tbl [16][3];
  logic [2:0] ms [2];
  logic mcf [2];
  logic mzf [2];

  always #5 clk = ~clk;

  control_sequencer #(.NUM_STEPS(5), .STEP_W(3), .EARLY_END(1)) u_ee (
    .clk(clk), .clr(clr), .ena(ena), .opcode(opcode), .carry_in(carry_in), .zero_in(zero_in),
    .control_word(cw_e), .step(st_e), .CF(cf_e), .ZF(zf_e), .halted(h_e));
  control_sequencer #(.NUM_STEPS(5), .STEP_W(3), .EARLY_END(0)) u_ne (
    .clk(clk), .clr(clr), .ena(ena), .opcode(opcode), .carry_in(carry_in), .zero_in(zero_in),
    .control_word(cw_n), .step(st_n), .CF(cf_n), .ZF(zf_n), .halted(h_n));

  function automatic logic [15:0] uword(input logic [3:0] op, input logic [2:0] st, input logic cf, input logic zf);
    if (st == 3'd0) return 16'h2002;
    if (st == 3'd1) return 16'h1028;
    if (st > 3'd4) return 16'h0000;
    if (op == 4'h7) return (st == 3'd2 && cf) ? 16'h4010 : 16'h0000;
    if (op == 4'h8) return (st == 3'd2 && zf) ? 16'h4010 : 16'h0000;
    return tbl[op][st - 3'd2];
  endfunction

  task automatic cyc(input logic c_clr, input logic c_ena, input logic [3:0] op, input logic ci, input logic zi);
    logic [15:0] w;
    @(posedge clk);
    #1;
    clr = c_clr; ena = c_ena; opcode = op; carry_in = ci; zero_in = zi;
    cycle++;
    for (int k = 0; k < 2; k++) begin
      w = uword(op, ms[k], mcf[k], mzf[k]);
      if (k == 0) q_e.push_back({w, ms[k], mcf[k], mzf[k], w[0]});
      else        q_n.push_back({w, ms[k], mcf[k], mzf[k], w[0]});
      if (!c_clr) begin
        ms[k] = 3'd0; mcf[k] = 1'b0; mzf[k] = 1'b0;
      end else if (c_ena) begin
        if (w[15]) begin mcf[k] = ci; mzf[k] = zi; end
        if (!w[0]) ms[k] = (k == 0 && ms[k] >= 3'd2 && w == 16'h0000) || ms[k] == 3'd4 ? 3'd0 : ms[k] + 3'd1;
      end
    end
  endtask

  task automatic run(input logic [3:0] op, input int n, input logic ci, input logic zi);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, op, ci, zi);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q_e.size() > 0) begin
        logic [21:0] x, a;
        x = q_e.pop_front();
        a = {cw_e, st_e, cf_e, zf_e, h_e};
        total++;
        if (a !== x) begin
          bad++;
          $display("FAIL early_end=1 cyc=%0d {cw,step,cf,zf,halted} got %h/%0d/%b/%b/%b want %h/%0d/%b/%b/%b",
                   cycle, a[21:6], a[5:3], a[2], a[1], a[0], x[21:6], x[5:3], x[2], x[1], x[0]);
        end
      end
      if (q_n.size() > 0) begin
        logic [21:0] x, a;
        x = q_n.pop_front();
        a = {cw_n, st_n, cf_n, zf_n, h_n};
        total++;
        if (a !== x) begin
          bad++;
          $display("FAIL early_end=0 cyc=%0d {cw,step,cf,zf,halted} got %h/%0d/%b/%b/%b want %h/%0d/%b/%b/%b",
                   cycle, a[21:6], a[5:3], a[2], a[1], a[0], x[21:6], x[5:3], x[2], x[1], x[0]);
        end
      end
    end
  end

  initial begin
    logic [3:0] op;
    for (int i = 0; i < 16; i++) for (int j = 0; j < 3; j++) tbl[i][j] = 16'h0000;
    tbl[1][0] = 16'h0012; tbl[1][1] = 16'h0048;
    tbl[2][0] = 16'h0012; tbl[2][1] = 16'h0408; tbl[2][2] = 16'h8140;
    tbl[3][0] = 16'h0012; tbl[3][1] = 16'h0408; tbl[3][2] = 16'h8340;
    tbl[4][0] = 16'h0012; tbl[4][1] = 16'h0084;
    tbl[5][0] = 16'h0050;
    tbl[6][0] = 16'h4010;
    tbl[14][0] = 16'h0880;
    tbl[15][0] = 16'h0001;
    for (int k = 0; k < 2; k++) begin ms[k] = 3'd0; mcf[k] = 1'b0; mzf[k] = 1'b0; end
    cyc(1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
    run(4'h1, 7, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 4'h2, 1'b1, 1'b0);
    run(4'h2, 6, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 4'h7, 1'b0, 1'b0);
    run(4'h7, 5, 1'b0, 1'b0);
    run(4'h2, 5, 1'b1, 1'b1);
    run(4'h7, 4, 1'b0, 1'b0);
    run(4'h8, 4, 1'b0, 1'b0);
    run(4'h3, 5, 1'b0, 1'b1);
    run(4'h8, 4, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
    run(4'hF, 14, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
    run(4'h3, 3, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 4'h3, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 4'h3, 1'b1, 1'b1);
    run(4'h3, 6, 1'b1, 1'b1);
    op = 4'h0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(0, 15));
      cyc($urandom_range(0, 24) != 0, $urandom_range(0, 4) != 0, op,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (2) @(posedge clk);
    total++;
    if (q_e.size() + q_n.size() != 0) begin
      bad++;
      $display("FAIL drain pending got %0d want 0", q_e.size() + q_n.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
